// File: rtl/pll_sup_pkg.sv
// Shared definitions for the audio PLL supervisor: state encoding, the status
// bundle driven by each state, and the default timing for a 50 MHz refclk.
package pll_sup_pkg;

   typedef logic [2:0] pll_state_t;

   localparam pll_state_t ST_RESET_PLL = 3'd0;
   localparam pll_state_t ST_WAIT_LOCK = 3'd1;
   localparam pll_state_t ST_STABLE    = 3'd2;
   localparam pll_state_t ST_RUN       = 3'd3;
   localparam pll_state_t ST_FAULT     = 3'd4;

   typedef struct packed {
      logic pll_rst;
      logic audio_rst;
      logic ready;
      logic fault;
   } pll_sts_t;

   // 50 MHz refclk: 1 ms lock timeout, ~20 us of stable lock before RUN.
   localparam int DEF_RST_PULSE_CYCLES    = 20;
   localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
   localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
   localparam int DEF_MAX_RETRIES         = 3;
   localparam int DEF_LOSS_CNT_W          = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Moore decode; anything unrecognised drives the safe reset-like pattern.
   function automatic pll_sts_t state_outputs(input pll_state_t st);
      pll_sts_t s;
      s = '{pll_rst: 1'b1, audio_rst: 1'b1, ready: 1'b0, fault: 1'b0};
      case (st)
         ST_WAIT_LOCK, ST_STABLE: s.pll_rst = 1'b0;
         ST_RUN: begin
            s.pll_rst   = 1'b0;
            s.audio_rst = 1'b0;
            s.ready     = 1'b1;
         end
         ST_FAULT: s.fault = 1'b1;
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/pll_audio_supervisor_bit_sync_2ff.sv
// Generic two-flop synchronizer for level signals crossing into the local clock;
// output lags the input by two clock edges.
module bit_sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_audio_supervisor.sv
// Audio PLL supervisor: pulses the PLL reset, waits for lock with timeout and
// retries, debounces lock, then releases the audio-domain reset.
module pll_audio_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
   parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
   parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
   parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
   parameter int LOSS_CNT_W          = DEF_LOSS_CNT_W
) (
   input  logic                               refclk,
   input  logic                               rst,
   input  logic                               pll_locked,
   input  logic                               relock_req,
   output logic                               pll_rst,
   output logic                               audio_rst,
   output logic                               ready,
   output logic                               fault,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
   output logic [LOSS_CNT_W-1:0]              loss_count
);

   localparam int TMR_MAX = max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam int RETRY_W = $clog2(MAX_RETRIES+1);

   localparam logic [TMR_W-1:0]   RST_LAST = TMR_W'(RST_PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0]   TMO_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0]   STB_LAST = TMR_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRIES);

   pll_state_t         state, state_nxt;
   logic [TMR_W-1:0]   timer;
   logic [RETRY_W-1:0] retry_nxt, retry_inc;
   logic               restart, loss_inc, lock_s;
   pll_sts_t           sts;

   bit_sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   assign retry_inc = retry_count + 1'b1;

   always_comb begin
      state_nxt = state;
      retry_nxt = retry_count;
      restart   = 1'b0;
      loss_inc  = 1'b0;
      case (state)
         ST_RESET_PLL: begin
            if (relock_req)
               restart = 1'b1;
            else if (timer == RST_LAST)
               state_nxt = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (relock_req)
               state_nxt = ST_RESET_PLL;
            else if (lock_s)
               state_nxt = ST_STABLE;
            else if (timer == TMO_LAST) begin
               retry_nxt = retry_inc;
               state_nxt = (retry_inc == RETRY_LIM) ? ST_FAULT : ST_RESET_PLL;
            end
         end
         ST_STABLE: begin
            // Any dropout restarts the debounce from WAIT_LOCK with a fresh timeout.
            if (relock_req)
               state_nxt = ST_RESET_PLL;
            else if (!lock_s)
               state_nxt = ST_WAIT_LOCK;
            else if (timer == STB_LAST) begin
               state_nxt = ST_RUN;
               retry_nxt = '0;
            end
         end
         ST_RUN: begin
            if (!lock_s) begin
               state_nxt = ST_RESET_PLL;
               loss_inc  = 1'b1;
            end else if (relock_req)
               state_nxt = ST_RESET_PLL;
         end
         ST_FAULT: begin
            if (relock_req) begin
               state_nxt = ST_RESET_PLL;
               retry_nxt = '0;
            end
         end
         default: state_nxt = ST_RESET_PLL;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state       <= ST_RESET_PLL;
         timer       <= '0;
         retry_count <= '0;
         loss_count  <= '0;
         sts         <= state_outputs(ST_RESET_PLL);
      end else begin
         state       <= state_nxt;
         retry_count <= retry_nxt;
         sts         <= state_outputs(state_nxt);
         if (restart || (state_nxt != state))
            timer <= '0;
         else if ((state != ST_RUN) && (state != ST_FAULT))
            timer <= timer + 1'b1;
         if (loss_inc && !(&loss_count))
            loss_count <= loss_count + 1'b1;
      end
   end

   assign pll_rst   = sts.pll_rst;
   assign audio_rst = sts.audio_rst;
   assign ready     = sts.ready;
   assign fault     = sts.fault;

endmodule

// File: tb/tb_pll_audio_supervisor.sv
// Bench for pll_audio_supervisor: fixed vector table, hand-written corner cases
// and random stimulus, all checked against a countdown-based phase model.
module tb_pll_audio_supervisor;

   localparam int RP  = 4;
   localparam int TO  = 16;
   localparam int STB = 8;
   localparam int MR  = 2;
   localparam int LW  = 8;
   localparam int LOSS_MAX = (1 << LW) - 1;

   logic          refclk = 1'b0;
   logic          rst = 1'b1, pll_locked = 1'b0, relock_req = 1'b0;
   logic          pll_rst, audio_rst, ready, fault;
   logic [1:0]    retry_count;
   logic [LW-1:0] loss_count;

   int n_chk = 0;
   int n_fail = 0;

   pll_audio_supervisor #(
      .RST_PULSE_CYCLES    (RP),
      .LOCK_TIMEOUT_CYCLES (TO),
      .LOCK_STABLE_CYCLES  (STB),
      .MAX_RETRIES         (MR),
      .LOSS_CNT_W          (LW)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .relock_req  (relock_req),
      .pll_rst     (pll_rst),
      .audio_rst   (audio_rst),
      .ready       (ready),
      .fault       (fault),
      .retry_count (retry_count),
      .loss_count  (loss_count)
   );

   always #5 refclk = ~refclk;

   // Reference model: a phase plus the number of cycles left in it.
   typedef enum int {P_RST, P_WAIT, P_STAB, P_RUN, P_FLT} phase_e;
   phase_e ph;
   int     left, m_retry, m_loss;
   logic   ms1, ms2;

   task automatic enter_rst();
      ph = P_RST;
      left = RP;
   endtask

   task automatic model_reset();
      enter_rst();
      m_retry = 0;
      m_loss  = 0;
      ms1 = 1'b0;
      ms2 = 1'b0;
   endtask

   task automatic model_step(input logic r, input logic lk, input logic rq);
      logic ls;
      ls  = ms2;
      ms2 = ms1;
      ms1 = lk;
      if (r) begin
         model_reset();
         return;
      end
      case (ph)
         P_RST: begin
            if (rq) enter_rst();
            else begin
               left--;
               if (left == 0) begin ph = P_WAIT; left = TO; end
            end
         end
         P_WAIT: begin
            if (rq) enter_rst();
            else if (ls) begin ph = P_STAB; left = STB; end
            else begin
               left--;
               if (left == 0) begin
                  m_retry++;
                  if (m_retry == MR) ph = P_FLT;
                  else enter_rst();
               end
            end
         end
         P_STAB: begin
            if (rq) enter_rst();
            else if (!ls) begin ph = P_WAIT; left = TO; end
            else begin
               left--;
               if (left == 0) begin ph = P_RUN; m_retry = 0; end
            end
         end
         P_RUN: begin
            if (!ls) begin
               if (m_loss < LOSS_MAX) m_loss++;
               enter_rst();
            end else if (rq) enter_rst();
         end
         P_FLT: begin
            if (rq) begin m_retry = 0; enter_rst(); end
         end
         default: enter_rst();
      endcase
   endtask

   function automatic logic [31:0] dut_vec();
      return {18'd0, pll_rst, audio_rst, ready, fault, retry_count, loss_count};
   endfunction

   function automatic logic [31:0] model_vec();
      logic [1:0]    rc;
      logic [LW-1:0] lc;
      rc = 2'(m_retry);
      lc = LW'(m_loss);
      return {18'd0, (ph == P_RST || ph == P_FLT), (ph != P_RUN), (ph == P_RUN),
              (ph == P_FLT), rc, lc};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input logic r, input logic lk, input logic rq);
      rst = r;
      pll_locked = lk;
      relock_req = rq;
      @(posedge refclk);
      model_step(r, lk, rq);
      @(negedge refclk);
      check("model", dut_vec(), model_vec());
   endtask

   task automatic ticks(input int n, input logic r, input logic lk, input logic rq);
      for (int i = 0; i < n; i++) tick(r, lk, rq);
   endtask

   typedef struct {
      logic r, lk, rq;
      int   n;
      logic pr, ar, rdy, flt;
      int   rc, lc;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic r, input logic lk, input logic rq, input int n,
                      input logic pr, input logic ar, input logic rdy, input logic flt,
                      input int rc, input int lc);
      vec_t v;
      v = '{r, lk, rq, n, pr, ar, rdy, flt, rc, lc};
      tbl.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic lk;
      model_reset();

      //   r  lk rq  n   pr ar rdy flt rc lc
      add(1, 1, 0,  2,  1, 1, 0,  0,  0, 0);  // reset values
      add(0, 1, 0,  3,  1, 1, 0,  0,  0, 0);  // pll_rst still high
      add(0, 1, 0,  1,  0, 1, 0,  0,  0, 0);  // 4-cycle pulse ends
      add(0, 1, 0,  8,  0, 1, 0,  0,  0, 0);  // still debouncing
      add(0, 1, 0,  1,  0, 0, 1,  0,  0, 0);  // RUN 13 edges after release
      add(0, 0, 0,  2,  0, 0, 1,  0,  0, 0);  // loss not yet through sync
      add(0, 0, 0,  1,  1, 1, 0,  0,  0, 1);  // third edge: loss seen
      add(0, 0, 0,  4,  0, 1, 0,  0,  0, 1);  // waiting for lock
      add(0, 0, 0, 15,  0, 1, 0,  0,  0, 1);
      add(0, 0, 0,  1,  1, 1, 0,  0,  1, 1);  // first timeout
      add(0, 0, 0, 19,  0, 1, 0,  0,  1, 1);
      add(0, 0, 0,  1,  1, 1, 0,  1,  2, 1);  // second timeout -> FAULT
      add(0, 1, 0,  6,  1, 1, 0,  1,  2, 1);  // lock ignored in FAULT
      add(0, 0, 0,  3,  1, 1, 0,  1,  2, 1);
      add(0, 1, 0,  3,  1, 1, 0,  1,  2, 1);
      add(0, 1, 1,  1,  1, 1, 0,  0,  0, 1);  // relock clears fault
      add(0, 1, 0,  3,  1, 1, 0,  0,  0, 1);
      add(0, 1, 0,  1,  0, 1, 0,  0,  0, 1);
      add(0, 1, 0,  1,  0, 1, 0,  0,  0, 1);
      add(0, 1, 0,  7,  0, 1, 0,  0,  0, 1);
      add(0, 1, 0,  1,  0, 0, 1,  0,  0, 1);  // back in RUN
      add(0, 0, 0,  3,  1, 1, 0,  0,  0, 2);  // second loss
      add(0, 0, 0,  2,  1, 1, 0,  0,  0, 2);  // pulse cycle 2
      add(1, 0, 0,  1,  1, 1, 0,  0,  0, 0);  // rst mid-pulse

      foreach (tbl[k]) begin
         ticks(tbl[k].n, tbl[k].r, tbl[k].lk, tbl[k].rq);
         check($sformatf("table[%0d]", k), dut_vec(),
               {18'd0, tbl[k].pr, tbl[k].ar, tbl[k].rdy, tbl[k].flt,
                2'(tbl[k].rc), LW'(tbl[k].lc)});
      end

      // One-cycle lock glitch at stable count 5.
      ticks(2, 1, 1, 0);
      ticks(9, 0, 1, 0);
      tick(0, 0, 0);
      ticks(10, 0, 1, 0);
      check("glitch_not_ready", {31'd0, ready}, 32'd0);
      tick(0, 1, 0);
      check("glitch_ready", {30'd0, ready, audio_rst}, 32'd2);
      check("glitch_retry", {30'd0, retry_count}, 32'd0);

      // Lock loss and relock_req in the same cycle: loss still counted.
      ticks(2, 0, 0, 0);
      tick(0, 0, 1);
      check("same_cycle_loss", {24'd0, loss_count}, 32'd1);
      check("same_cycle_state", {29'd0, pll_rst, audio_rst, ready}, 32'd6);

      // Drive into FAULT, then rst there.
      ticks(40, 0, 0, 0);
      check("fault_reached", {29'd0, fault, retry_count}, 32'd6);
      tick(1, 0, 0);
      check("rst_in_fault", dut_vec(), 32'h3000);

      // Saturating loss counter.
      for (int i = 0; i < 256; i++) begin
         ticks(13, 0, 1, 0);
         ticks(3, 0, 0, 0);
         if (i == 254) check("loss_255", {24'd0, loss_count}, 32'd255);
      end
      check("loss_saturated", {24'd0, loss_count}, 32'd255);

      // Random stimulus with a slowly varying lock input.
      lk = 1'b1;
      tick(1, lk, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39, 0) == 0) lk = ~lk;
         tick(($urandom_range(499, 0) == 0), lk, ($urandom_range(59, 0) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
